// File: rtl/reservation_station_bank.sv
// Multi-entry reservation station in front of a single FU: allocates into the lowest free
// slot, wakes operands from the CDB, issues the lowest ready slot, frees on its own CDB tag.

module rs_entry #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5,
    parameter int CTRL_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 alloc_i,
    input  logic                 q1_valid_i,
    input  logic [TAG_WIDTH-1:0] q1_i,
    input  logic [XLEN-1:0]      v1_i,
    input  logic                 q2_valid_i,
    input  logic [TAG_WIDTH-1:0] q2_i,
    input  logic [XLEN-1:0]      v2_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    input  logic [TAG_WIDTH-1:0] rob_tag_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_WIDTH-1:0] cdb_rob_tag_i,
    input  logic [XLEN-1:0]      cdb_data_i,
    input  logic                 issue_i,
    output logic                 free_o,
    output logic                 ready_o,
    output logic [TAG_WIDTH-1:0] rob_tag_o,
    output logic [XLEN-1:0]      v1_o,
    output logic [XLEN-1:0]      v2_o,
    output logic [CTRL_W-1:0]    ctrl_o
);
    typedef enum logic [1:0] {FREE, WAITING, READY, ISSUED} state_e;

    state_e                 state_q, state_d;
    logic                   q1v_q, q1v_d, q2v_q, q2v_d;
    logic [TAG_WIDTH-1:0]   q1_q, q1_d, q2_q, q2_d, tag_q, tag_d;
    logic [XLEN-1:0]        v1_q, v1_d, v2_q, v2_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic                   hit1, hit2, byp1, byp2;

    assign hit1 = cdb_valid_i && q1v_q && (cdb_rob_tag_i == q1_q);
    assign hit2 = cdb_valid_i && q2v_q && (cdb_rob_tag_i == q2_q);
    assign byp1 = cdb_valid_i && q1_valid_i && (cdb_rob_tag_i == q1_i);
    assign byp2 = cdb_valid_i && q2_valid_i && (cdb_rob_tag_i == q2_i);

    always_comb begin
        state_d = state_q;
        q1v_d   = q1v_q;
        q1_d    = q1_q;
        v1_d    = v1_q;
        q2v_d   = q2v_q;
        q2_d    = q2_q;
        v2_d    = v2_q;
        tag_d   = tag_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            FREE: if (alloc_i) begin
                tag_d  = rob_tag_i;
                ctrl_d = ctrl_i;
                // A producer broadcasting in the dispatch cycle resolves the operand on entry.
                q1v_d  = q1_valid_i && !byp1;
                q1_d   = q1v_d ? q1_i : '0;
                v1_d   = q1v_d ? '0 : (q1_valid_i ? cdb_data_i : v1_i);
                q2v_d  = q2_valid_i && !byp2;
                q2_d   = q2v_d ? q2_i : '0;
                v2_d   = q2v_d ? '0 : (q2_valid_i ? cdb_data_i : v2_i);
                state_d = (q1v_d || q2v_d) ? WAITING : READY;
            end
            WAITING: begin
                if (hit1) begin
                    q1v_d = 1'b0;
                    q1_d  = '0;
                    v1_d  = cdb_data_i;
                end
                if (hit2) begin
                    q2v_d = 1'b0;
                    q2_d  = '0;
                    v2_d  = cdb_data_i;
                end
                if (!q1v_d && !q2v_d) state_d = READY;
            end
            READY: if (issue_i) state_d = ISSUED;
            ISSUED: if (cdb_valid_i && (cdb_rob_tag_i == tag_q)) begin
                state_d = FREE;
                q1v_d   = 1'b0;
                q1_d    = '0;
                v1_d    = '0;
                q2v_d   = 1'b0;
                q2_d    = '0;
                v2_d    = '0;
                tag_d   = '0;
                ctrl_d  = '0;
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            state_q <= FREE;
            q1v_q   <= 1'b0;
            q1_q    <= '0;
            v1_q    <= '0;
            q2v_q   <= 1'b0;
            q2_q    <= '0;
            v2_q    <= '0;
            tag_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            q1v_q   <= q1v_d;
            q1_q    <= q1_d;
            v1_q    <= v1_d;
            q2v_q   <= q2v_d;
            q2_q    <= q2_d;
            v2_q    <= v2_d;
            tag_q   <= tag_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign free_o    = (state_q == FREE);
    assign ready_o   = (state_q == READY);
    assign rob_tag_o = tag_q;
    assign v1_o      = v1_q;
    assign v2_o      = v2_q;
    assign ctrl_o    = ctrl_q;
endmodule

module reservation_station_bank #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5,
    parameter int DEPTH     = 4,
    parameter int CTRL_W    = 8,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic                 q1_valid_i,
    input  logic [TAG_WIDTH-1:0] q1_i,
    input  logic [XLEN-1:0]      v1_i,
    input  logic                 q2_valid_i,
    input  logic [TAG_WIDTH-1:0] q2_i,
    input  logic [XLEN-1:0]      v2_i,
    input  logic [CTRL_W-1:0]    control_signals_i,
    input  logic [TAG_WIDTH-1:0] rob_tag_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_WIDTH-1:0] cdb_rob_tag_i,
    input  logic [XLEN-1:0]      cdb_data_i,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [XLEN-1:0]      issue_v1_o,
    output logic [XLEN-1:0]      issue_v2_o,
    output logic [CTRL_W-1:0]    issue_control_signals_o,
    output logic [TAG_WIDTH-1:0] issue_rob_tag_o,
    output logic [IDX_W-1:0]     issue_index_o,
    output logic [CNT_W-1:0]     busy_count_o,
    output logic                 full_o,
    output logic                 empty_o
);
    logic [DEPTH-1:0]                free_w, ready_w, alloc_sel, issue_sel;
    logic [DEPTH-1:0][TAG_WIDTH-1:0] tag_w;
    logic [DEPTH-1:0][XLEN-1:0]      v1_w, v2_w;
    logic [DEPTH-1:0][CTRL_W-1:0]    ctrl_w;
    logic [IDX_W-1:0]                alloc_idx, issue_idx;
    logic                            alloc_found, issue_found;
    logic [CNT_W-1:0]                busy;

    // Descending scan so the lowest index wins for both allocation and issue.
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        issue_idx   = '0;
        issue_found = 1'b0;
        busy        = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_w[i]) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
            if (ready_w[i]) begin
                issue_idx   = IDX_W'(i);
                issue_found = 1'b1;
            end
            busy = busy + CNT_W'(!free_w[i]);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign alloc_sel[g] = alloc_valid_i && alloc_found && (alloc_idx == IDX_W'(g));
        assign issue_sel[g] = issue_ready_i && issue_found && (issue_idx == IDX_W'(g));

        rs_entry #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .CTRL_W(CTRL_W)) u_ent (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .flush_i       (flush_i),
            .alloc_i       (alloc_sel[g]),
            .q1_valid_i    (q1_valid_i),
            .q1_i          (q1_i),
            .v1_i          (v1_i),
            .q2_valid_i    (q2_valid_i),
            .q2_i          (q2_i),
            .v2_i          (v2_i),
            .ctrl_i        (control_signals_i),
            .rob_tag_i     (rob_tag_i),
            .cdb_valid_i   (cdb_valid_i),
            .cdb_rob_tag_i (cdb_rob_tag_i),
            .cdb_data_i    (cdb_data_i),
            .issue_i       (issue_sel[g]),
            .free_o        (free_w[g]),
            .ready_o       (ready_w[g]),
            .rob_tag_o     (tag_w[g]),
            .v1_o          (v1_w[g]),
            .v2_o          (v2_w[g]),
            .ctrl_o        (ctrl_w[g])
        );
    end

    assign alloc_ready_o           = alloc_found;
    assign issue_valid_o           = issue_found;
    assign issue_v1_o              = issue_found ? v1_w[issue_idx]   : '0;
    assign issue_v2_o              = issue_found ? v2_w[issue_idx]   : '0;
    assign issue_control_signals_o = issue_found ? ctrl_w[issue_idx] : '0;
    assign issue_rob_tag_o         = issue_found ? tag_w[issue_idx]  : '0;
    assign issue_index_o           = issue_found ? issue_idx         : '0;
    assign busy_count_o            = busy;
    assign full_o                  = (busy == CNT_W'(DEPTH));
    assign empty_o                 = (busy == '0);
endmodule
